// File: rtl/uart_rx_buffer.sv
// Receive-side FWFT buffer: captures a word on each rising edge of rx_done, with backpressure and overrun flag.
// Optional: define UART_RX_OVERRUN_CNT_EN to add the saturating 8-bit overrun_count output.
module uart_rx_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [DATA_WIDTH-1:0]      r_input,
  input  logic                       rx_done,
  input  logic                       rd_en,
  input  logic                       clr_overrun,
  output logic [DATA_WIDTH-1:0]      r_out,
  output logic                       rx_data_ready,
  output logic                       rx_empty,
  output logic                       rx_full,
  output logic [$clog2(DEPTH):0]     rx_count,
`ifdef UART_RX_OVERRUN_CNT_EN
  output logic [7:0]                 overrun_count,
`endif
  output logic                       rx_overrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic                  rx_done_q;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  overrun_q, overrun_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic capture, full, empty, pop, push, drop;

  assign capture = rx_done & ~rx_done_q;
  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign pop     = rd_en & ~empty;
  // A full FIFO still accepts a word when the head leaves on the same edge.
  assign push    = capture & (~full | pop);
  assign drop    = capture & full & ~pop;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
    if (drop)             overrun_d = 1'b1;
    else if (clr_overrun) overrun_d = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_done_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      rx_done_q <= rx_done;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  // NOTE: storage is deliberately not reset; count_q gates every read, so stale contents are never seen.
  always_ff @(posedge clock) begin
    if (reset && push) mem_q[wr_ptr_q] <= r_input;
  end

`ifdef UART_RX_OVERRUN_CNT_EN
  logic [7:0] ovr_cnt_q, ovr_cnt_d;

  always_comb begin
    ovr_cnt_d = ovr_cnt_q;
    if (drop) begin
      if (clr_overrun)              ovr_cnt_d = 8'd1;
      else if (ovr_cnt_q != 8'hFF)  ovr_cnt_d = ovr_cnt_q + 8'd1;
    end else if (clr_overrun) begin
      ovr_cnt_d = 8'd0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) ovr_cnt_q <= 8'd0;
    else        ovr_cnt_q <= ovr_cnt_d;
  end

  assign overrun_count = ovr_cnt_q;
`endif

  assign r_out         = empty ? '0 : mem_q[rd_ptr_q];
  assign rx_data_ready = ~empty;
  assign rx_empty      = empty;
  assign rx_full       = full;
  assign rx_count      = count_q;
  assign rx_overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Directed self-checking bench for uart_rx_buffer (DATA_WIDTH=8, DEPTH=4).
module tb_uart_rx_buffer;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] r_input;
  logic       rx_done, rd_en, clr_overrun;
  logic [7:0] r_out;
  logic       rx_data_ready, rx_empty, rx_full, rx_overrun;
  logic [2:0] rx_count;
`ifdef UART_RX_OVERRUN_CNT_EN
  logic [7:0] overrun_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  uart_rx_buffer #(.DATA_WIDTH(8), .DEPTH(4)) dut (
    .clock         (clock),
    .reset         (reset),
    .r_input       (r_input),
    .rx_done       (rx_done),
    .rd_en         (rd_en),
    .clr_overrun   (clr_overrun),
    .r_out         (r_out),
    .rx_data_ready (rx_data_ready),
    .rx_empty      (rx_empty),
    .rx_full       (rx_full),
    .rx_count      (rx_count),
`ifdef UART_RX_OVERRUN_CNT_EN
    .overrun_count (overrun_count),
`endif
    .rx_overrun    (rx_overrun)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle; inputs are changed and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic capture(input logic [7:0] d);
    r_input = d;
    rx_done = 1'b1;
    step();
    rx_done = 1'b0;
    step();
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] d);
    check(tag, r_out, d);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_r_out"}, r_out, 0);
    check({tag, "_ready"}, rx_data_ready, 0);
    check({tag, "_empty"}, rx_empty, 1);
    check({tag, "_full"}, rx_full, 0);
    check({tag, "_count"}, rx_count, 0);
    check({tag, "_overrun"}, rx_overrun, 0);
`ifdef UART_RX_OVERRUN_CNT_EN
    check({tag, "_ovr_cnt"}, overrun_count, 0);
`endif
  endtask

  initial begin
    reset = 1'b0; r_input = '0; rx_done = 1'b0; rd_en = 1'b0; clr_overrun = 1'b0;
    step(); step();
    check_reset_state("rst");
    reset = 1'b1;

    // Single capture with strobe held three cycles.
    r_input = 8'hA5; rx_done = 1'b1;
    step();
    check("cap_count", rx_count, 1);
    check("cap_r_out", r_out, 8'hA5);
    check("cap_ready", rx_data_ready, 1);
    step(); step();
    check("held_count", rx_count, 1);
    rx_done = 1'b0;
    pop_expect("cap_pop", 8'hA5);
    check("cap_empty", rx_empty, 1);
    check("cap_r_out0", r_out, 0);

    // Fill and wrap.
    for (int i = 1; i <= 4; i++) capture(8'(i));
    check("fill_full", rx_full, 1);
    check("fill_count", rx_count, 4);
    pop_expect("wrap_p1", 8'h01);
    pop_expect("wrap_p2", 8'h02);
    capture(8'h05);
    capture(8'h06);
    check("wrap_count", rx_count, 4);
    pop_expect("wrap_p3", 8'h03);
    pop_expect("wrap_p4", 8'h04);
    pop_expect("wrap_p5", 8'h05);
    pop_expect("wrap_p6", 8'h06);
    check("wrap_empty", rx_empty, 1);

    // Pop while empty is ignored.
    rd_en = 1'b1; step(); rd_en = 1'b0;
    check("idle_pop_count", rx_count, 0);
    check("idle_pop_empty", rx_empty, 1);

    // Overrun.
    for (int i = 0; i < 4; i++) capture(8'h10 + 8'(i));
    capture(8'h99);
    check("ovr_flag", rx_overrun, 1);
    check("ovr_count", rx_count, 4);
    check("ovr_head", r_out, 8'h10);
`ifdef UART_RX_OVERRUN_CNT_EN
    check("ovr_cnt1", overrun_count, 1);
`endif
    clr_overrun = 1'b1; step(); clr_overrun = 1'b0;
    check("ovr_clr", rx_overrun, 0);
`ifdef UART_RX_OVERRUN_CNT_EN
    check("ovr_cnt_clr", overrun_count, 0);
`endif
    for (int i = 0; i < 4; i++) pop_expect($sformatf("ovr_drain%0d", i), 8'h10 + 8'(i));

    // Push and pop on the same edge while full.
    for (int i = 0; i < 4; i++) capture(8'h20 + 8'(i));
    r_input = 8'h77; rx_done = 1'b1; rd_en = 1'b1;
    step();
    rx_done = 1'b0; rd_en = 1'b0;
    check("sim_full_count", rx_count, 4);
    check("sim_full_ovr", rx_overrun, 0);
    step();
    pop_expect("sim_p1", 8'h21);
    pop_expect("sim_p2", 8'h22);
    pop_expect("sim_p3", 8'h23);
    pop_expect("sim_p4", 8'h77);
    check("sim_empty", rx_empty, 1);

    // Push and pop on the same edge while empty.
    r_input = 8'h55; rx_done = 1'b1; rd_en = 1'b1;
    step();
    rx_done = 1'b0; rd_en = 1'b0;
    check("sim_empty_count", rx_count, 1);
    check("sim_empty_r_out", r_out, 8'h55);
    step();
    pop_expect("sim_empty_pop", 8'h55);

    // Drop coincident with clear: set wins.
    for (int i = 0; i < 4; i++) capture(8'h30 + 8'(i));
    r_input = 8'hEE; rx_done = 1'b1; clr_overrun = 1'b1;
    step();
    rx_done = 1'b0; clr_overrun = 1'b0;
    check("set_wins_flag", rx_overrun, 1);
`ifdef UART_RX_OVERRUN_CNT_EN
    check("set_wins_cnt", overrun_count, 1);
`endif
    step();

    // Saturation: 300 dropped words on a full FIFO.
    for (int i = 0; i < 300; i++) capture(8'hC0);
    check("sat_flag", rx_overrun, 1);
    check("sat_count", rx_count, 4);
    check("sat_head", r_out, 8'h30);
`ifdef UART_RX_OVERRUN_CNT_EN
    check("sat_cnt", overrun_count, 255);
`endif
    clr_overrun = 1'b1; step(); clr_overrun = 1'b0;
    for (int i = 0; i < 4; i++) rd_en = 1'b1;
    step(); step(); step(); step();
    rd_en = 1'b0;
    check("sat_drained", rx_empty, 1);

    // Reset mid-operation with rx_done held across the release.
    capture(8'h41); capture(8'h42); capture(8'h43);
    check("mid_count", rx_count, 3);
    r_input = 8'h3C; rx_done = 1'b1; reset = 1'b0;
    step();
    check_reset_state("mid_rst");
    reset = 1'b1;
    step();
    check("rel_count", rx_count, 1);
    check("rel_r_out", r_out, 8'h3C);
    step(); step();
    check("rel_held_count", rx_count, 1);
    rx_done = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
